// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-file address width, Tnew encoding and
// the hazard-control bundle carried by every stage register and the hazard unit.
package pipe_pkg;

  localparam int RFA_W      = 5;
  localparam int TNEW_W_DEF = 3;

  localparam logic [TNEW_W_DEF-1:0] TNEW_NONE = '0;
  localparam logic [TNEW_W_DEF-1:0] TNEW_MAX  = '1;

  typedef struct packed {
    logic                  valid;
    logic                  rfwe;
    logic [RFA_W-1:0]      rfwa;
    logic [TNEW_W_DEF-1:0] tnew;
  } ctl_t;

endpackage

// File: rtl/tnew_sat_dec.sv
// Saturating decrement of a Tnew value: counts down to zero and stays there.
module tnew_sat_dec
  import pipe_pkg::*;
#(
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic [TNEW_W-1:0] tnew,
  output logic [TNEW_W-1:0] tnew_dec
);

  assign tnew_dec = (tnew == '0) ? '0 : tnew - TNEW_W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable MIPS pipeline stage register with stall/flush, Tnew countdown,
// registered forwarding-ready flag and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int TNEW_W      = pipe_pkg::TNEW_W_DEF,
  parameter int RFA_W       = pipe_pkg::RFA_W,
  parameter int CNT_W       = 16,
  parameter bit DEC_ON_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  input  logic              in_rfwe,
  input  logic [RFA_W-1:0]  in_rfwa,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  output logic              out_rfwe,
  output logic [RFA_W-1:0]  out_rfwa,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_payload,
  output logic              fwd_ok,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  logic              vld_p0, vld_p1;
  logic              rfwe_p0, rfwe_p1;
  logic [RFA_W-1:0]  rfwa_p0, rfwa_p1;
  logic [TNEW_W-1:0] tnew_p0, tnew_p1;
  logic [31:0]       pc_p0, pc_p1;
  logic [DATA_W-1:0] payload_p0, payload_p1;
  logic              fwd_p0, fwd_p1;
  logic [CNT_W-1:0]  cnt_p0, cnt_p1;
  logic [TNEW_W-1:0] tnew_in_dec, tnew_hold_dec;

  tnew_sat_dec #(.TNEW_W(TNEW_W)) u_dec_in (
    .tnew     (in_tnew),
    .tnew_dec (tnew_in_dec)
  );

  tnew_sat_dec #(.TNEW_W(TNEW_W)) u_dec_hold (
    .tnew     (tnew_p1),
    .tnew_dec (tnew_hold_dec)
  );

  // Stage input (p0): next-state selection, priority flush > stall > load
  always_comb begin
    vld_p0     = vld_p1;
    rfwe_p0    = rfwe_p1;
    rfwa_p0    = rfwa_p1;
    tnew_p0    = tnew_p1;
    pc_p0      = pc_p1;
    payload_p0 = payload_p1;
    if (flush || (!stall && !in_valid)) begin
      vld_p0     = 1'b0;
      rfwe_p0    = 1'b0;
      rfwa_p0    = '0;
      tnew_p0    = '0;
      pc_p0      = '0;
      payload_p0 = '0;
    end else if (stall) begin
      if (DEC_ON_HOLD) tnew_p0 = tnew_hold_dec;
    end else begin
      vld_p0     = 1'b1;
      rfwe_p0    = in_rfwe;
      rfwa_p0    = in_rfwa;
      tnew_p0    = tnew_in_dec;
      pc_p0      = in_pc;
      payload_p0 = in_payload;
    end
    fwd_p0 = vld_p0 && rfwe_p0 && (rfwa_p0 != '0) && (tnew_p0 == TNEW_W'(TNEW_NONE));

    cnt_p0 = cnt_p1;
    if (clr_cnt) cnt_p0 = '0;
    else if (stall && !flush && vld_p1) cnt_p0 = sat_inc(cnt_p1);
  end

  // Stage output (p1): the registered stage contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      rfwe_p1    <= 1'b0;
      rfwa_p1    <= '0;
      tnew_p1    <= '0;
      pc_p1      <= '0;
      payload_p1 <= '0;
      fwd_p1     <= 1'b0;
      cnt_p1     <= '0;
    end else begin
      vld_p1     <= vld_p0;
      rfwe_p1    <= rfwe_p0;
      rfwa_p1    <= rfwa_p0;
      tnew_p1    <= tnew_p0;
      pc_p1      <= pc_p0;
      payload_p1 <= payload_p0;
      fwd_p1     <= fwd_p0;
      cnt_p1     <= cnt_p0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_rfwe    = rfwe_p1;
  assign out_rfwa    = rfwa_p1;
  assign out_tnew    = tnew_p1;
  assign out_pc      = pc_p1;
  assign out_payload = payload_p1;
  assign fwd_ok      = fwd_p1;
  assign stall_cnt   = cnt_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, Tnew frozen on hold, 4-bit counter)
// share one stimulus stream; a vector table feeds a scoreboard queue.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0, flush = 1'b0, clr_cnt = 1'b0;
  logic         in_valid = 1'b0, in_rfwe = 1'b0;
  logic [4:0]   in_rfwa = '0;
  logic [2:0]   in_tnew = '0;
  logic [31:0]  in_pc = '0;
  logic [127:0] in_payload = '0;

  logic         v_a, we_a, fwd_a, v_n, we_n, fwd_n, v_c, we_c, fwd_c;
  logic [4:0]   wa_a, wa_n, wa_c;
  logic [2:0]   tn_a, tn_n, tn_c;
  logic [31:0]  pc_a, pc_n, pc_c;
  logic [127:0] pl_a, pl_n, pl_c;
  logic [15:0]  cnt_a, cnt_n;
  logic [3:0]   cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(128), .CNT_W(16), .DEC_ON_HOLD(1'b1)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_rfwe(in_rfwe), .in_rfwa(in_rfwa), .in_tnew(in_tnew),
    .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(v_a), .out_rfwe(we_a), .out_rfwa(wa_a), .out_tnew(tn_a),
    .out_pc(pc_a), .out_payload(pl_a), .fwd_ok(fwd_a), .stall_cnt(cnt_a));

  pipe_stage_reg #(.DATA_W(128), .CNT_W(16), .DEC_ON_HOLD(1'b0)) u_dut_nd (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_rfwe(in_rfwe), .in_rfwa(in_rfwa), .in_tnew(in_tnew),
    .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(v_n), .out_rfwe(we_n), .out_rfwa(wa_n), .out_tnew(tn_n),
    .out_pc(pc_n), .out_payload(pl_n), .fwd_ok(fwd_n), .stall_cnt(cnt_n));

  pipe_stage_reg #(.DATA_W(128), .CNT_W(4), .DEC_ON_HOLD(1'b1)) u_dut_c4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_rfwe(in_rfwe), .in_rfwa(in_rfwa), .in_tnew(in_tnew),
    .in_pc(in_pc), .in_payload(in_payload),
    .out_valid(v_c), .out_rfwe(we_c), .out_rfwa(wa_c), .out_tnew(tn_c),
    .out_pc(pc_c), .out_payload(pl_c), .fwd_ok(fwd_c), .stall_cnt(cnt_c));

  typedef struct {
    logic st, fl, clr, v, we;
    logic [4:0] wa;
    logic [2:0] tn;
    logic [31:0] pc;
    logic [127:0] pl;
    logic e_v, e_we;
    logic [4:0] e_wa;
    logic [2:0] e_tn, e_tn_nd;
    logic e_fwd;
    logic [31:0] e_pc;
    logic [127:0] e_pl;
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [127:0] PA = {4{32'hDEADBEEF}};
  localparam logic [127:0] PB = {4{32'h11112222}};
  localparam logic [127:0] PC = {4{32'h33334444}};
  localparam logic [127:0] PD = {4{32'hCAFEF00D}};
  localparam logic [127:0] PE = {4{32'h55556666}};
  localparam logic [127:0] PF = {4{32'h0BADC0DE}};
  localparam logic [127:0] PG = {4{32'h77778888}};
  localparam logic [127:0] PH = {4{32'h9999AAAA}};

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input int st, input int fl, input int clr, input int v,
                              input int we, input int wa, input int tn, input int pc,
                              input logic [127:0] pl, input int ev, input int ewe,
                              input int ewa, input int etn, input int etnnd, input int efwd,
                              input int epc, input logic [127:0] epl, input int ecnt);
    vec_t r;
    r.st = 1'(st); r.fl = 1'(fl); r.clr = 1'(clr); r.v = 1'(v); r.we = 1'(we);
    r.wa = 5'(wa); r.tn = 3'(tn); r.pc = 32'(pc); r.pl = pl;
    r.e_v = 1'(ev); r.e_we = 1'(ewe); r.e_wa = 5'(ewa); r.e_tn = 3'(etn);
    r.e_tn_nd = 3'(etnnd); r.e_fwd = 1'(efwd); r.e_pc = 32'(epc); r.e_pl = epl;
    r.e_cnt = 16'(ecnt);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic clr, input logic v,
                       input logic we, input logic [4:0] wa, input logic [2:0] tn,
                       input logic [31:0] pc, input logic [127:0] pl);
    stall = st; flush = fl; clr_cnt = clr; in_valid = v; in_rfwe = we;
    in_rfwa = wa; in_tnew = tn; in_pc = pc; in_payload = pl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, 128'(v_a), 0);     chk({tag, " rfwe"}, 128'(we_a), 0);
    chk({tag, " rfwa"}, 128'(wa_a), 0);     chk({tag, " tnew"}, 128'(tn_a), 0);
    chk({tag, " pc"}, 128'(pc_a), 0);       chk({tag, " payload"}, pl_a, 0);
    chk({tag, " fwd_ok"}, 128'(fwd_a), 0);  chk({tag, " stall_cnt"}, 128'(cnt_a), 0);
    chk({tag, " nd bundle"}, {v_n, we_n, wa_n, tn_n, pc_n, fwd_n, cnt_n}, 0);
    chk({tag, " nd payload"}, pl_n, 0);
    chk({tag, " c4 bundle"}, {v_c, we_c, wa_c, tn_c, pc_c, fwd_c, cnt_c}, 0);
    chk({tag, " c4 payload"}, pl_c, 0);
  endtask

  initial begin
    vec_t e;
    //            st fl clr v we wa tn pc      pl  | ev ewe ewa etn nd fwd epc    epl cnt
    tbl.push_back(mk(0,0,0, 1,1, 5, 3,'h100, PA,  1,1, 5, 2,2, 0,'h100, PA, 0));
    tbl.push_back(mk(0,0,0, 1,1, 5, 1,'h104, PB,  1,1, 5, 0,0, 1,'h104, PB, 0));
    tbl.push_back(mk(0,0,0, 1,1, 5, 0,'h108, PC,  1,1, 5, 0,0, 1,'h108, PC, 0));
    tbl.push_back(mk(0,0,0, 1,1, 0, 3,'h10C, PA,  1,1, 0, 2,2, 0,'h10C, PA, 0));
    tbl.push_back(mk(0,0,0, 1,1, 0, 1,'h110, PB,  1,1, 0, 0,0, 0,'h110, PB, 0));
    tbl.push_back(mk(0,0,0, 1,1, 0, 0,'h114, PC,  1,1, 0, 0,0, 0,'h114, PC, 0));
    tbl.push_back(mk(0,0,0, 1,1, 9, 3,'h200, PD,  1,1, 9, 2,2, 0,'h200, PD, 0));
    tbl.push_back(mk(1,0,0, 1,1, 3, 0,'h300, PE,  1,1, 9, 1,2, 0,'h200, PD, 1));
    tbl.push_back(mk(1,0,0, 1,1, 3, 0,'h300, PE,  1,1, 9, 0,2, 1,'h200, PD, 2));
    tbl.push_back(mk(1,0,0, 1,1, 3, 0,'h300, PE,  1,1, 9, 0,2, 1,'h200, PD, 3));
    tbl.push_back(mk(1,0,0, 1,1, 3, 0,'h300, PE,  1,1, 9, 0,2, 1,'h200, PD, 4));
    tbl.push_back(mk(1,1,0, 1,1, 3, 0,'h300, PE,  0,0, 0, 0,0, 0,    0,  0, 4));
    tbl.push_back(mk(0,0,0, 1,1, 7, 2,'h400, PF,  1,1, 7, 1,1, 0,'h400, PF, 4));
    tbl.push_back(mk(0,0,0, 0,1,31, 0,'h500, PG,  0,0, 0, 0,0, 0,    0,  0, 4));
    tbl.push_back(mk(1,0,0, 1,1, 6, 2,'h504, PG,  0,0, 0, 0,0, 0,    0,  0, 4));
    tbl.push_back(mk(0,0,0, 1,0, 4, 0,'h600, PH,  1,0, 4, 0,0, 0,'h600, PH, 4));
    tbl.push_back(mk(1,0,1, 1,1, 2, 3,'h604, PA,  1,0, 4, 0,0, 0,'h600, PH, 0));
    tbl.push_back(mk(0,1,0, 1,1, 2, 3,'h608, PA,  0,0, 0, 0,0, 0,    0,  0, 0));

    // Reset state
    #2;
    chk_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].st, tbl[i].fl, tbl[i].clr, tbl[i].v, tbl[i].we, tbl[i].wa,
            tbl[i].tn, tbl[i].pc, tbl[i].pl);
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d valid", i), 128'(v_a), 128'(e.e_v));
      chk($sformatf("row%0d rfwe", i), 128'(we_a), 128'(e.e_we));
      chk($sformatf("row%0d rfwa", i), 128'(wa_a), 128'(e.e_wa));
      chk($sformatf("row%0d tnew", i), 128'(tn_a), 128'(e.e_tn));
      chk($sformatf("row%0d tnew_nohold", i), 128'(tn_n), 128'(e.e_tn_nd));
      chk($sformatf("row%0d fwd_ok", i), 128'(fwd_a), 128'(e.e_fwd));
      chk($sformatf("row%0d pc", i), 128'(pc_a), 128'(e.e_pc));
      chk($sformatf("row%0d payload", i), pl_a, e.e_pl);
      chk($sformatf("row%0d stall_cnt", i), 128'(cnt_a), 128'(e.e_cnt));
    end

    // Asynchronous reset while holding a valid instruction
    @(negedge clk);
    drive(0,0,0, 1,1, 5'd8, 3'd2, 32'h700, PA);
    @(posedge clk); #1;
    chk("rst_seq load tnew", 128'(tn_a), 1);
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("rst_seq hold cnt", 128'(cnt_a), 1);
    chk("rst_seq hold payload", pl_a, PA);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    drive(0,0,0, 1,1, 5'd8, 3'd0, 32'h704, PB);
    @(posedge clk); #1;
    chk("rst_release valid", 128'(v_a), 1);
    chk("rst_release fwd_ok", 128'(fwd_a), 1);
    chk("rst_release pc", 128'(pc_a), 32'h704);
    chk("rst_release payload", pl_a, PB);

    // Counter saturation on the 4-bit instance, then clear-with-stall
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 20; k++) @(posedge clk);
    #1;
    chk("sat c4 stall_cnt", 128'(cnt_c), 15);
    chk("sat wide stall_cnt", 128'(cnt_a), 20);
    chk("sat hold pc", 128'(pc_c), 32'h704);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    chk("clr c4 stall_cnt", 128'(cnt_c), 0);
    chk("clr wide stall_cnt", 128'(cnt_a), 0);
    @(negedge clk);
    clr_cnt = 1'b0;
    @(posedge clk); #1;
    chk("after clr c4 stall_cnt", 128'(cnt_c), 1);
    @(negedge clk);
    drive(0,0,0, 0,0, 5'd0, 3'd0, 32'h0, 128'h0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
